// File: rtl/gpio_pkg.sv
// gpio_pkg: register offsets and edge-capture mode encodings for mmio_gpio.
package gpio_pkg;
    typedef enum logic [1:0] {
        GPIO_LED_DATA = 2'd0,
        GPIO_LED_TGL  = 2'd1,
        GPIO_SW_STATE = 2'd2,
        GPIO_SW_EDGE  = 2'd3
    } gpio_reg_e;
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_BOTH = 2;
endpackage

// File: rtl/gpio_debounce.sv
// gpio_debounce: one switch channel; 2-FF synchroniser followed by a stability counter.
module gpio_debounce #(
    parameter int DB_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic i_sw,
    output logic o_deb
);
    localparam int CW = $clog2(DB_CYCLES + 1);
    logic          r_s1;
    logic          r_s2;
    logic          r_deb;
    logic [CW-1:0] r_cnt;
    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1  <= 1'b0;
            r_s2  <= 1'b0;
            r_deb <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_s1 <= i_sw;
            r_s2 <= r_s1;
            if (r_s2 == r_deb) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DB_CYCLES - 1)) begin
                r_deb <= r_s2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end
    assign o_deb = r_deb;
endmodule

// File: rtl/mmio_gpio.sv
// mmio_gpio: memory-mapped LED outputs and debounced switch inputs with sticky edge flags.
// Reads are combinational; writes commit on the next rising clock edge.
module mmio_gpio
    import gpio_pkg::*;
#(
    parameter int LED_W     = 24,
    parameter int SW_W      = 24,
    parameter int DB_CYCLES = 16,
    parameter int EDGE_MODE = EDGE_RISE
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_sel,
    input  logic             io_read,
    input  logic             io_write,
    input  logic [3:0]       addr,
    input  logic [31:0]      write_data,
    output logic [31:0]      read_data,
    input  logic [SW_W-1:0]  switches,
    output logic [LED_W-1:0] leds,
    output logic             edge_irq
);
    logic [LED_W-1:0] r_leds;
    logic [SW_W-1:0]  r_deb_prev;
    logic [SW_W-1:0]  r_sw_edge;
    logic [SW_W-1:0]  w_deb;
    logic [SW_W-1:0]  w_ev;
    logic [SW_W-1:0]  w_clr;
    gpio_reg_e        w_reg;
    logic             w_wr;
    logic             w_unused;

    assign w_reg    = gpio_reg_e'(addr[3:2]);
    assign w_wr     = io_sel & io_write;
    assign w_unused = &{1'b0, addr[1:0], write_data};

    for (genvar i = 0; i < SW_W; i++) begin : g_db
        gpio_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clock (clock),
            .reset (reset),
            .i_sw  (switches[i]),
            .o_deb (w_deb[i])
        );
    end

    assign w_ev  = (EDGE_MODE == EDGE_FALL) ? (~w_deb & r_deb_prev) :
                   (EDGE_MODE == EDGE_BOTH) ? (w_deb ^ r_deb_prev) :
                                              (w_deb & ~r_deb_prev);
    assign w_clr = (w_wr && w_reg == GPIO_SW_EDGE) ? write_data[SW_W-1:0] : '0;

    // A new event ORs in after the clear, so set wins over a same-cycle W1C.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_leds     <= '0;
            r_deb_prev <= '0;
            r_sw_edge  <= '0;
        end else begin
            if (w_wr && w_reg == GPIO_LED_DATA)
                r_leds <= write_data[LED_W-1:0];
            else if (w_wr && w_reg == GPIO_LED_TGL)
                r_leds <= r_leds ^ write_data[LED_W-1:0];
            r_deb_prev <= w_deb;
            r_sw_edge  <= (r_sw_edge & ~w_clr) | w_ev;
        end
    end

    always_comb begin
        read_data = '0;
        if (io_sel && io_read)
            read_data = (w_reg == GPIO_LED_DATA) ? 32'(r_leds) :
                        (w_reg == GPIO_SW_STATE) ? 32'(w_deb) :
                        (w_reg == GPIO_SW_EDGE)  ? 32'(r_sw_edge) : 32'h0;
    end

    assign leds     = r_leds;
    assign edge_irq = |r_sw_edge;
endmodule

// File: tb/tb_mmio_gpio.sv
// tb_mmio_gpio: scoreboard bench for mmio_gpio; one both-edge build and one rising-edge build
// share stimulus and are checked against a window-based behavioural model.
module tb_mmio_gpio;
    localparam int DB = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        io_sel = 1'b0;
    logic        io_read = 1'b0;
    logic        io_write = 1'b0;
    logic [3:0]  addr = 4'h0;
    logic [31:0] write_data = 32'h0;
    logic [23:0] switches = 24'h0;
    logic [31:0] read_data, read_data0;
    logic [23:0] leds, leds0;
    logic        edge_irq, edge_irq0;

    int total = 0;
    int bad = 0;

    mmio_gpio #(.LED_W(24), .SW_W(24), .DB_CYCLES(DB), .EDGE_MODE(2)) dut (
        .clock(clock), .reset(reset), .io_sel(io_sel), .io_read(io_read), .io_write(io_write),
        .addr(addr), .write_data(write_data), .read_data(read_data), .switches(switches),
        .leds(leds), .edge_irq(edge_irq)
    );
    mmio_gpio #(.LED_W(24), .SW_W(24), .DB_CYCLES(DB), .EDGE_MODE(0)) dut0 (
        .clock(clock), .reset(reset), .io_sel(io_sel), .io_read(io_read), .io_write(io_write),
        .addr(addr), .write_data(write_data), .read_data(read_data0), .switches(switches),
        .leds(leds0), .edge_irq(edge_irq0)
    );

    always #5 clock = ~clock;

    // Model: deb flips once the last DB synchronised samples all disagree with it.
    logic [23:0] m_leds = 0, m_deb = 0, m_prev = 0, m_edge = 0, m_edge0 = 0, m_p1 = 0, m_p2 = 0;
    logic [23:0] m_hist[$];

    always @(posedge clock) begin
        logic [23:0] ev, ev0, clr, nd;
        bit          flip;
        if (reset) begin
            m_leds = 0; m_deb = 0; m_prev = 0; m_edge = 0; m_edge0 = 0; m_p1 = 0; m_p2 = 0;
            m_hist.delete();
        end else begin
            ev  = m_deb ^ m_prev;
            ev0 = m_deb & ~m_prev;
            clr = (io_sel && io_write && addr[3:2] == 2'd3) ? write_data[23:0] : 24'h0;
            m_edge  = (m_edge & ~clr) | ev;
            m_edge0 = (m_edge0 & ~clr) | ev0;
            m_prev  = m_deb;
            m_hist.push_back(m_p2);
            if (m_hist.size() > DB) void'(m_hist.pop_front());
            nd = m_deb;
            for (int i = 0; i < 24; i++) begin
                flip = (m_hist.size() == DB);
                foreach (m_hist[j]) if (m_hist[j][i] == m_deb[i]) flip = 0;
                if (flip) nd[i] = ~m_deb[i];
            end
            m_deb = nd;
            m_p2 = m_p1;
            m_p1 = switches;
            if (io_sel && io_write && addr[3:2] == 2'd0) m_leds = write_data[23:0];
            else if (io_sel && io_write && addr[3:2] == 2'd1) m_leds = m_leds ^ write_data[23:0];
        end
    end

    typedef struct {
        logic [31:0] rd;
        logic [31:0] rd0;
        logic [23:0] leds;
        logic        irq;
        logic        irq0;
    } exp_t;
    exp_t sb[$];

    function automatic logic [31:0] exp_of(input logic [3:0] a, input bit m0);
        case (a[3:2])
            2'd0:    return {8'h0, m_leds};
            2'd1:    return 32'h0;
            2'd2:    return {8'h0, m_deb};
            default: return {8'h0, m0 ? m_edge0 : m_edge};
        endcase
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h at %0t", n, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (io_sel && io_read) begin
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL sb_underflow got=read expected=none at %0t", $time);
            end else begin
                e = sb.pop_front();
                chk("read_data", read_data, e.rd);
                chk("read_data_m0", read_data0, e.rd0);
                chk("leds", {8'h0, leds}, {8'h0, e.leds});
                chk("leds_m0", {8'h0, leds0}, {8'h0, e.leds});
                chk("edge_irq", {31'h0, edge_irq}, {31'h0, e.irq});
                chk("edge_irq_m0", {31'h0, edge_irq0}, {31'h0, e.irq0});
            end
        end else begin
            chk("idle_read", read_data, 32'h0);
            chk("idle_read_m0", read_data0, 32'h0);
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic push(input logic [31:0] e, input logic [31:0] e0);
        exp_t x;
        x.rd = e; x.rd0 = e0; x.leds = m_leds; x.irq = |m_edge; x.irq0 = |m_edge0;
        sb.push_back(x);
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] e, input logic [31:0] e0);
        io_sel = 1; io_read = 1; io_write = 0; addr = a;
        push(e, e0);
        cyc();
        io_sel = 0; io_read = 0;
    endtask

    task automatic rd_m(input logic [3:0] a);
        rd(a, exp_of(a, 0), exp_of(a, 1));
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        io_sel = 1; io_write = 1; io_read = 0; addr = a; write_data = d;
        cyc();
        io_sel = 0; io_write = 0;
    endtask

    task automatic rdwr(input logic [3:0] a, input logic [31:0] d);
        io_sel = 1; io_write = 1; io_read = 1; addr = a; write_data = d;
        push(exp_of(a, 0), exp_of(a, 1));
        cyc();
        io_sel = 0; io_write = 0; io_read = 0;
    endtask

    initial begin
        cyc(3);
        reset = 0;
        rd(4'h0, 32'h0, 32'h0);
        rd(4'hC, 32'h0, 32'h0);
        wr(4'h0, 32'hFFAA5501);
        rd(4'h0, 32'h00AA5501, 32'h00AA5501);
        wr(4'h0, 32'h5);
        wr(4'h4, 32'hF);
        rd(4'h4, 32'h0, 32'h0);
        rd(4'h3, 32'h0000000A, 32'h0000000A);
        // held input from reset release
        reset = 1; switches = 24'h1;
        cyc();
        reset = 0;
        cyc(5);
        rd(4'h8, 32'h0, 32'h0);
        rd(4'h8, 32'h1, 32'h1);
        rd(4'hC, 32'h1, 32'h1);
        // 3-cycle glitch on bit 3
        switches = 24'h9;
        cyc(3);
        switches = 24'h1;
        cyc(6);
        rd(4'h8, 32'h1, 32'h1);
        rd(4'hC, 32'h1, 32'h1);
        // W1C and set-wins collision
        reset = 1; switches = 24'h0;
        cyc();
        reset = 0;
        switches = 24'h9;
        cyc(7);
        rd(4'hC, 32'h9, 32'h9);
        wr(4'hC, 32'h1);
        rd(4'hC, 32'h8, 32'h8);
        switches = 24'h8;
        cyc(6);
        wr(4'hC, 32'h1);
        rd(4'hC, 32'h9, 32'h8);
        wr(4'h8, 32'hFFFFFFFF);
        rd(4'h8, 32'h8, 32'h8);
        // reset mid-debounce
        wr(4'h0, 32'hFFFFFF);
        switches = 24'hF0;
        cyc(3);
        reset = 1;
        cyc();
        rd(4'h0, 32'h0, 32'h0);
        rd(4'h8, 32'h0, 32'h0);
        rd(4'hC, 32'h0, 32'h0);
        reset = 0;
        cyc(5);
        rd(4'h8, 32'h0, 32'h0);
        rd(4'h8, 32'hF0, 32'hF0);
        for (int k = 0; k < 600; k++) begin
            int op;
            logic [3:0] a;
            op = $urandom_range(0, 11);
            a = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) switches = switches ^ 24'(1 << $urandom_range(0, 23));
            case (op)
                0, 1:    wr(a, $urandom);
                2, 3, 4: rd_m(a);
                5:       rdwr(a, $urandom);
                6: begin
                    io_read = 1; addr = a;
                    cyc();
                    io_read = 0;
                end
                7: begin
                    if ($urandom_range(0, 15) == 0) begin
                        reset = 1;
                        cyc();
                        reset = 0;
                    end else cyc();
                end
                default: cyc($urandom_range(1, 6));
            endcase
        end
        cyc(2);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover got=%0d expected=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
